// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared constants, FSM states and ID encoding for intr_ctrl
package intr_ctrl_pkg;

    localparam int NUM_SRC = 8;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_ID      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // {valid, 4'b0, index of lowest set request}
    function automatic logic [7:0] id_word(input logic [NUM_SRC-1:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
        return {|req, 4'b0000, idx};
    endfunction

endpackage

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - single-bit multi-flop synchroniser for an asynchronous level input
module intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - 8-source interrupt controller with level/edge pending, masking and IRQ gap FSM
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata,
    output logic               IRQ,
    output logic [NUM_SRC-1:0] IREQ
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam int         ARM_W    = SYNC_STAGES + 2;

    logic [NUM_SRC-1:0] src_sync;
    logic [NUM_SRC-1:0] src_q, src_prev_q;
    logic [ARM_W-1:0]   arm_q;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] rise, w1c, masked;
    logic               mask_we, edge_we, pend_we;
    state_t             state_q, state_d;
    logic [3:0]         gap_q, gap_d;
    logic               irq_q, irq_d;
    logic [NUM_SRC-1:0] ireq_q, ireq_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (PCLK),
            .rst_ni (PRESETn),
            .d_i    (irq_src[i]),
            .q_o    (src_sync[i])
        );
    end

    assign mask_we = cfg_we && (cfg_addr == ADDR_MASK);
    assign edge_we = cfg_we && (cfg_addr == ADDR_EDGE);
    assign pend_we = cfg_we && (cfg_addr == ADDR_PENDING);
    assign masked  = pend_q & mask_q;

    // Edges are ignored until the sync pipeline has filled after reset, so a
    // source already high at release does not look like a 0->1 transition.
    always_comb begin
        mask_d = mask_we ? cfg_wdata : mask_q;
        edge_d = edge_we ? cfg_wdata : edge_q;
        rise   = arm_q[ARM_W-1] ? (src_q & ~src_prev_q) : '0;
        w1c    = pend_we ? cfg_wdata : '0;
        pend_d = (edge_q & (rise | (pend_q & ~w1c))) | (~edge_q & src_q);
        if (edge_we) begin
            pend_d = pend_d & ~(edge_q ^ cfg_wdata);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            src_q      <= '0;
            src_prev_q <= '0;
            arm_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            pend_q     <= '0;
        end else begin
            src_q      <= src_sync;
            src_prev_q <= src_q;
            arm_q      <= {arm_q[ARM_W-2:0], 1'b1};
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            pend_q     <= pend_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (|masked) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!(|masked)) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_d  = (state_d == ST_ASSERT);
        ireq_d = masked;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_q  <= 1'b0;
            ireq_q <= '0;
        end else begin
            irq_q  <= irq_d;
            ireq_q <= ireq_d;
        end
    end

    assign IRQ  = irq_q;
    assign IREQ = ireq_q;

    always_comb begin
        case (cfg_addr)
            ADDR_MASK:    cfg_rdata = mask_q;
            ADDR_EDGE:    cfg_rdata = edge_q;
            ADDR_PENDING: cfg_rdata = pend_q;
            default:      cfg_rdata = id_word(masked);
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - scoreboard bench for intr_ctrl: IRQ transitions checked against queued expectations
`timescale 1ns/1ps
module tb_intr_ctrl;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_PEND = 2'd2;
    localparam logic [1:0] A_ID   = 2'd3;

    logic       PCLK;
    logic       PRESETn;
    logic [7:0] irq_src;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       IRQ;
    logic [7:0] IREQ;

    typedef struct {
        string      name;
        logic       irq;
        logic [7:0] ireq;
        int         cmin;
        int         cmax;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic irq_prev;

    intr_ctrl #(.SYNC_STAGES(2), .GAP_CYCLES(2)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .IRQ       (IRQ),
        .IREQ      (IREQ)
    );

    initial begin
        PCLK = 1'b0;
        forever #10 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge PCLK);
        cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        cfg_addr = a;
        #1;
        check(name, {24'd0, cfg_rdata}, {24'd0, exp});
    endtask

    task automatic expect_tr(input string name, input logic irq, input logic [7:0] ireq,
                             input int dmin, input int dmax);
        exp_t e;
        e.name = name;
        e.irq  = irq;
        e.ireq = ireq;
        e.cmin = cyc + dmin;
        e.cmax = cyc + dmax;
        exp_q.push_back(e);
    endtask

    // Every change on IRQ must match the next queued expectation, in value and cycle window.
    initial begin
        exp_t e;
        irq_prev = 1'b0;
        forever begin
            @(negedge PCLK);
            if (IRQ !== irq_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL irq_unexpected: IRQ went to %0b IREQ=0x%0h at cycle %0d, required no change",
                             IRQ, IREQ, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_irq"}, {31'd0, IRQ}, {31'd0, e.irq});
                    check({e.name, "_ireq"}, {24'd0, IREQ}, {24'd0, e.ireq});
                    n_checks++;
                    if (cyc < e.cmin || cyc > e.cmax) begin
                        n_errors++;
                        $display("FAIL %s_cycle: got cycle %0d required %0d..%0d", e.name, cyc, e.cmin, e.cmax);
                    end
                end
                irq_prev = IRQ;
            end
        end
    end

    initial begin
        PRESETn   = 1'b0;
        irq_src   = 8'h00;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 8'h00;
        tick(3);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_ireq", {24'd0, IREQ}, 32'd0);
        PRESETn = 1'b1;
        rd(A_MASK, 8'h00, "rst_mask");
        rd(A_EDGE, 8'h00, "rst_edge");
        rd(A_PEND, 8'h00, "rst_pend");
        rd(A_ID,   8'h00, "rst_id");
        tick(8);

        // level mode
        wr(A_MASK, 8'hFF);
        wr(A_EDGE, 8'h00);
        expect_tr("lvl_rise", 1'b1, 8'h04, 5, 5);
        irq_src = 8'h04;
        tick(8);
        rd(A_PEND, 8'h04, "lvl_pend");
        rd(A_ID, 8'h82, "lvl_id");
        expect_tr("lvl_fall", 1'b0, 8'h00, 5, 5);
        irq_src = 8'h00;
        tick(10);

        // edge mode and W1C
        wr(A_EDGE, 8'hFF);
        expect_tr("edge_rise", 1'b1, 8'h80, 5, 5);
        irq_src = 8'h80;
        tick(3);
        irq_src = 8'h00;
        tick(5);
        check("edge_hold", {24'd0, IREQ}, 32'h80);
        expect_tr("w1c_fall", 1'b0, 8'h00, 2, 2);
        wr(A_PEND, 8'h80);
        tick(6);
        rd(A_PEND, 8'h00, "w1c_pend");

        // masking, ID, read-only ID
        wr(A_MASK, 8'h01);
        expect_tr("mask_rise", 1'b1, 8'h01, 5, 5);
        irq_src = 8'h03;
        tick(3);
        irq_src = 8'h00;
        tick(4);
        rd(A_ID, 8'h80, "mask_id");
        rd(A_PEND, 8'h03, "mask_pend");
        expect_tr("mask_fall", 1'b0, 8'h00, 2, 2);
        wr(A_MASK, 8'h00);
        tick(1);
        wr(A_PEND, 8'h03);
        wr(A_ID, 8'hFF);
        rd(A_ID, 8'h00, "id_ro");
        rd(A_MASK, 8'h00, "mask_zero");
        tick(4);

        // new edge lands inside GAP
        wr(A_MASK, 8'hFF);
        expect_tr("gap_first", 1'b1, 8'h01, 5, 5);
        irq_src = 8'h01;
        tick(3);
        irq_src = 8'h00;
        tick(3);
        expect_tr("gap_fall", 1'b0, 8'h00, 4, 4);
        expect_tr("gap_rise", 1'b1, 8'h02, 6, 7);
        irq_src = 8'h02;
        tick(2);
        wr(A_PEND, 8'h01);
        irq_src = 8'h00;
        tick(6);
        expect_tr("gap_clr", 1'b0, 8'h00, 2, 2);
        wr(A_PEND, 8'h02);
        tick(6);

        // set/clear collision on bit 3
        expect_tr("col_rise", 1'b1, 8'h08, 5, 5);
        irq_src = 8'h08;
        tick(3);
        irq_src = 8'h00;
        tick(5);
        irq_src = 8'h08;
        tick(3);
        wr(A_PEND, 8'h08);
        tick(2);
        rd(A_PEND, 8'h08, "col_pend");
        check("col_ireq", {24'd0, IREQ}, 32'h08);

        // asynchronous reset mid-ASSERT
        expect_tr("arst_fall", 1'b0, 8'h00, 0, 1);
        PRESETn = 1'b0;
        #1;
        check("arst_irq", {31'd0, IRQ}, 32'd0);
        check("arst_ireq", {24'd0, IREQ}, 32'd0);
        rd(A_MASK, 8'h00, "arst_mask");
        rd(A_EDGE, 8'h00, "arst_edge");
        rd(A_PEND, 8'h00, "arst_pend");
        rd(A_ID,   8'h00, "arst_id");
        tick(2);

        // release with source 3 still high: no edge may be seen
        PRESETn = 1'b1;
        wr(A_EDGE, 8'hFF);
        wr(A_MASK, 8'hFF);
        tick(8);
        rd(A_PEND, 8'h00, "no_spurious_pend");
        check("no_spurious_irq", {31'd0, IRQ}, 32'd0);

        irq_src = 8'h00;
        tick(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
